// File: rtl/l2_reqs_arb.sv
// Request-buffer port arbiter: picks one of lookup/fwd/cpu/flush per two-cycle
// slot, drives the op code, pulses the matching grant, and tracks free entries.
`ifndef N_REQS
`define N_REQS 4
`endif
`ifndef L2_REQS_IDLE
`define L2_REQS_IDLE       3'd0
`endif
`ifndef L2_REQS_LOOKUP
`define L2_REQS_LOOKUP     3'd1
`endif
`ifndef L2_REQS_PEEK_FWD
`define L2_REQS_PEEK_FWD   3'd2
`endif
`ifndef L2_REQS_PEEK_REQ
`define L2_REQS_PEEK_REQ   3'd3
`endif
`ifndef L2_REQS_PEEK_FLUSH
`define L2_REQS_PEEK_FLUSH 3'd4
`endif

module l2_reqs_arb #(
  parameter int N_REQS     = `N_REQS,
  parameter int STARVE_MAX = 8,
  localparam int CW        = $clog2(N_REQS) + 1,
  localparam int SW        = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lookup_req,
  input  logic          fwd_req,
  input  logic          cpu_req,
  input  logic          flush_req,
  input  logic          cpu_stall,
  input  logic          alloc,
  input  logic          free,
  input  logic          peek_abort,
  output logic [2:0]    reqs_op_code,
  output logic          lookup_gnt,
  output logic          fwd_gnt,
  output logic          cpu_gnt,
  output logic          flush_gnt,
  output logic [CW-1:0] free_cnt,
  output logic          reqs_full,
  output logic          alloc_pending,
  output logic          cnt_err,
  output logic          dbg_state,
  output logic [SW-1:0] dbg_starve_cnt
);

  typedef enum logic {ST_IDLE, ST_RESULT} state_e;
  typedef enum logic [1:0] {W_LOOKUP, W_FWD, W_CPU, W_FLUSH} win_e;

  state_e        state_q, state_d;
  win_e          win_q, win_d;
  win_e          sel;
  logic          have_win;
  logic [SW-1:0] starve_q, starve_d;
  logic [CW-1:0] free_q, free_d;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic          elig_cpu, elig_flush, room;

  assign room       = (free_q != '0);
  assign elig_cpu   = cpu_req & ~cpu_stall & room & ~pend_q;
  assign elig_flush = flush_req & room & ~pend_q;

  // Grants come only from the latched winner, so they never depend on live reqs.
  assign lookup_gnt = (state_q == ST_RESULT) && (win_q == W_LOOKUP);
  assign fwd_gnt    = (state_q == ST_RESULT) && (win_q == W_FWD);
  assign cpu_gnt    = (state_q == ST_RESULT) && (win_q == W_CPU);
  assign flush_gnt  = (state_q == ST_RESULT) && (win_q == W_FLUSH);

  assign free_cnt       = free_q;
  assign reqs_full      = (free_q == '0);
  assign alloc_pending  = pend_q;
  assign cnt_err        = err_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    sel          = W_LOOKUP;
    have_win     = 1'b0;
    reqs_op_code = `L2_REQS_IDLE;
    case (state_q)
      ST_IDLE: begin
        have_win = 1'b1;
        if (elig_cpu && (starve_q == SW'(STARVE_MAX))) sel = W_CPU;
        else if (lookup_req)                           sel = W_LOOKUP;
        else if (fwd_req)                              sel = W_FWD;
        else if (elig_cpu)                             sel = W_CPU;
        else if (elig_flush)                           sel = W_FLUSH;
        else                                           have_win = 1'b0;
        if (have_win) begin
          win_d   = sel;
          state_d = ST_RESULT;
          case (sel)
            W_LOOKUP: reqs_op_code = `L2_REQS_LOOKUP;
            W_FWD:    reqs_op_code = `L2_REQS_PEEK_FWD;
            W_CPU:    reqs_op_code = `L2_REQS_PEEK_REQ;
            default:  reqs_op_code = `L2_REQS_PEEK_FLUSH;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (cpu_gnt) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (!cpu_req)
        starve_d = '0;
      else if (elig_cpu && !(have_win && sel == W_CPU) && starve_q != SW'(STARVE_MAX))
        starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (cpu_gnt || flush_gnt)  pend_d = 1'b1;
    else if (alloc || peek_abort) pend_d = 1'b0;
  end

  // Over/underflow leaves the count untouched and latches the error flag.
  always_comb begin
    free_d = free_q;
    err_d  = err_q;
    if (alloc && !free) begin
      if (free_q == '0) err_d = 1'b1;
      else              free_d = free_q - 1'b1;
    end else if (free && !alloc) begin
      if (free_q == CW'(N_REQS)) err_d = 1'b1;
      else                       free_d = free_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      win_q    <= W_LOOKUP;
      starve_q <= '0;
      free_q   <= CW'(N_REQS);
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      starve_q <= starve_d;
      free_q   <= free_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

endmodule
